mmio_io_unit: RTL and testbench

Memory-mapped I/O unit directly downstream of the single-cycle ARM core. It consumes the core's data-bus outputs (MemWrite, ALUResult as address, WriteData) and its exported ALUControl/RegWrite. It decodes an I/O window and gates writes to data memory. It holds the LED, switch and down-counter timer registers, and muxes the read data returned to the core.

---
 rtl/mmio_io_unit.sv | 128 ++++++++++++
 tb/tb_mmio_io_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mmio_io_unit.sv
// mmio_io_unit: memory-mapped I/O window (LED, timer, switches) beside the core's data memory
// Ports: clk/reset (async, active-high); mem_write/addr/wdata from the core bus;
//        alu_control/reg_write core activity; dmem_rdata/dmem_we data-memory side;
//        rdata read data to the core; sw_in switches; leds LEDs; timer_irq timer interrupt.
module mmio_io_unit #(
    parameter logic [31:0] IO_BASE  = 32'h0000_0400,
    parameter int          LED_W    = 8,
    parameter int          SW_W     = 8,
    parameter int          PRESCALE = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_write,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    input  logic [2:0]       alu_control,
    input  logic             reg_write,
    input  logic [31:0]      dmem_rdata,
    output logic             dmem_we,
    output logic [31:0]      rdata,
    input  logic [SW_W-1:0]  sw_in,
    output logic [LED_W-1:0] leds,
    output logic             timer_irq
);
    localparam int   PW   = $clog2(PRESCALE);
    localparam logic IDLE = 1'b0;
    localparam logic RUN  = 1'b1;

    logic [LED_W-1:0] led_q, led_d, alu_oh;
    logic [31:0]      load_q, load_d, count_q, count_d, ctrl_rd;
    logic [PW-1:0]    pcnt_q, pcnt_d;
    logic             en_q, en_d, auto_q, auto_d, done_q, done_d;
    logic             alu_mode_q, alu_mode_d, irq_en_q, irq_en_d;
    logic             state_q, state_d;
    logic [2:0]       last_alu_q, last_alu_d;
    logic [SW_W-1:0]  sw1_q, sw1_d, sw2_q, sw2_d;
    logic             io_sel, wr, wr_ctrl, tick, expire;
    logic [5:0]       off;
    logic             unused_addr;

    assign io_sel      = addr[31:8] == IO_BASE[31:8];
    assign off         = addr[7:2];
    assign wr          = mem_write & io_sel;
    assign wr_ctrl     = wr & (off == 6'd2);
    assign dmem_we     = mem_write & ~io_sel;
    assign unused_addr = ^addr[1:0];
    assign ctrl_rd     = {27'b0, irq_en_q, alu_mode_q, done_q, auto_q, en_q};
    assign rdata       = !io_sel      ? dmem_rdata :
                         off == 6'd0  ? 32'(led_q) :
                         off == 6'd1  ? load_q :
                         off == 6'd2  ? ctrl_rd :
                         off == 6'd3  ? count_q :
                         off == 6'd4  ? 32'(sw2_q) : '0;
    assign timer_irq   = done_q & irq_en_q;
    assign leds        = alu_mode_q ? alu_oh : led_q;

    always_comb begin
        alu_oh = '0;
        for (int i = 0; i < LED_W && i < 8; i++) alu_oh[i] = last_alu_q == 3'(i);
    end

    always_comb begin
        led_d      = wr & (off == 6'd0) ? wdata[LED_W-1:0] : led_q;
        load_d     = wr & (off == 6'd1) ? wdata : load_q;
        auto_d     = wr_ctrl ? wdata[1] : auto_q;
        alu_mode_d = wr_ctrl ? wdata[3] : alu_mode_q;
        irq_en_d   = wr_ctrl ? wdata[4] : irq_en_q;
        last_alu_d = reg_write ? alu_control : last_alu_q;
        sw1_d      = sw_in;
        sw2_d      = sw1_q;
        tick       = (state_q == RUN) && (pcnt_q == PW'(PRESCALE - 1));
        expire     = tick && (count_q <= 32'd1);
        // expiry set beats a same-cycle write-one-to-clear
        done_d     = expire | (done_q & ~(wr_ctrl & wdata[2]));
        en_d       = wr_ctrl ? wdata[0] : en_q;
        state_d    = state_q;
        count_d    = count_q;
        pcnt_d     = pcnt_q;
        if (state_q == IDLE) begin
            if (wr_ctrl && wdata[0]) begin
                state_d = RUN;
                count_d = load_d;
                pcnt_d  = '0;
            end
        end else if (wr_ctrl && !wdata[0]) begin
            state_d = IDLE;
        end else begin
            pcnt_d = tick ? '0 : pcnt_q + 1'b1;
            if (tick) count_d = expire ? (auto_q ? load_q : '0) : count_q - 32'd1;
            if (expire && !auto_q) begin
                state_d = IDLE;
                en_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q      <= '0;
            load_q     <= '0;
            count_q    <= '0;
            pcnt_q     <= '0;
            en_q       <= 1'b0;
            auto_q     <= 1'b0;
            done_q     <= 1'b0;
            alu_mode_q <= 1'b0;
            irq_en_q   <= 1'b0;
            state_q    <= IDLE;
            last_alu_q <= '0;
            sw1_q      <= '0;
            sw2_q      <= '0;
        end else begin
            led_q      <= led_d;
            load_q     <= load_d;
            count_q    <= count_d;
            pcnt_q     <= pcnt_d;
            en_q       <= en_d;
            auto_q     <= auto_d;
            done_q     <= done_d;
            alu_mode_q <= alu_mode_d;
            irq_en_q   <= irq_en_d;
            state_q    <= state_d;
            last_alu_q <= last_alu_d;
            sw1_q      <= sw1_d;
            sw2_q      <= sw2_d;
        end
    end
endmodule

// File: tb/tb_mmio_io_unit.sv
// tb_mmio_io_unit: randomized directed bench for mmio_io_unit with a prescale of 4
module tb_mmio_io_unit;
    logic        clk = 1'b0, reset, mem_write, reg_write, dmem_we, timer_irq;
    logic [31:0] addr, wdata, dmem_rdata, rdata;
    logic [2:0]  alu_control;
    logic [7:0]  sw_in, leds;
    int          total = 0, bad = 0;
    int          ld, n;
    logic [31:0] d, a;
    logic [7:0]  m_led, sw_old, sw_new, e_leds;
    logic [2:0]  alu;
    logic        mw;

    mmio_io_unit #(.PRESCALE(4)) dut (
        .clk(clk), .reset(reset), .mem_write(mem_write), .addr(addr), .wdata(wdata),
        .alu_control(alu_control), .reg_write(reg_write), .dmem_rdata(dmem_rdata),
        .dmem_we(dmem_we), .rdata(rdata), .sw_in(sw_in), .leds(leds), .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [31:0] ad, input logic [31:0] exp);
        addr = ad;
        mem_write = 1'b0;
        #1;
        chk(tag, rdata, exp);
    endtask

    task automatic wr(input logic [31:0] ad, input logic [31:0] dt);
        @(negedge clk);
        addr = ad;
        wdata = dt;
        mem_write = 1'b1;
        #1;
        chk("we_gate", {31'b0, dmem_we}, {31'b0, ad[31:8] != 24'h4});
        @(posedge clk);
        #1;
        mem_write = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_leds", {24'b0, leds}, 32'h0);
        chk("rst_irq", {31'b0, timer_irq}, 32'h0);
        rd("rst_count", 32'h40C, 32'h0);
        rd("rst_ctrl", 32'h408, 32'h0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; mem_write = 1'b0; reg_write = 1'b0; addr = '0; wdata = '0;
        dmem_rdata = 32'hDEAD_BEEF; alu_control = '0; sw_in = '0;
        #2;
        addr = 32'h100; mem_write = 1'b1; #1;
        chk("rst_dmem_we", {31'b0, dmem_we}, 32'h1);
        chk("rst_rdata_pass", rdata, 32'hDEAD_BEEF);
        mem_write = 1'b0;
        do_reset();

        // LED write/read and data-memory pass-through
        wr(32'h400, 32'h5A);
        rd("led_rd", 32'h400, 32'h5A);
        chk("led_out", {24'b0, leds}, 32'h5A);
        @(negedge clk);
        addr = 32'h100; mem_write = 1'b1; dmem_rdata = 32'h1234_5678; #1;
        chk("dmem_we", {31'b0, dmem_we}, 32'h1);
        chk("dmem_rdata", rdata, 32'h1234_5678);
        mem_write = 1'b0;

        // random register / bus traffic
        m_led = 8'h5A;
        for (int it = 0; it < 24; it++) begin
            d = $urandom;
            case ($urandom_range(0, 2))
                0: begin
                    wr(32'h400 | 32'($urandom_range(0, 3)), d);
                    m_led = d[7:0];
                    rd("rnd_led", 32'h400, {24'b0, m_led});
                    chk("rnd_leds", {24'b0, leds}, {24'b0, m_led});
                end
                1: begin
                    wr(32'h404, d);
                    rd("rnd_load", 32'h404, d);
                end
                default: begin
                    a = $urandom;
                    if (a[31:8] == 24'h4) a = a ^ 32'h8000_0000;
                    mw = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    addr = a; dmem_rdata = d; mem_write = mw; #1;
                    chk("rnd_dmem_we", {31'b0, dmem_we}, {31'b0, mw});
                    chk("rnd_rdata", rdata, d);
                    mem_write = 1'b0;
                end
            endcase
        end

        // unmapped offsets read 0 and ignore writes
        wr(32'h414, 32'hFFFF_FFFF);
        wr(32'h4FC, 32'hFFFF_FFFF);
        rd("unmap_14", 32'h414, 32'h0);
        rd("unmap_fc", 32'h4FC, 32'h0);
        rd("unmap_led", 32'h400, {24'b0, m_led});
        rd("unmap_ctrl", 32'h408, 32'h0);
        rd("unmap_count", 32'h40C, 32'h0);

        // one-shot timer: count L down, expire after L ticks of 4 clocks
        do_reset();
        ld = $urandom_range(1, 5);
        wr(32'h404, 32'(ld));
        wr(32'h408, 32'h11);
        rd("os_start", 32'h40C, 32'(ld));
        for (int k = 1; k <= 4 * ld + 4; k++) begin
            @(posedge clk); #1;
            n = k / 4;
            rd("os_count", 32'h40C, n >= ld ? 32'h0 : 32'(ld - n));
            chk("os_irq", {31'b0, timer_irq}, {31'b0, k >= 4 * ld});
        end
        rd("os_ctrl", 32'h408, 32'h14);

        // auto-reload with W1C, including a clear landing on the expiry edge
        do_reset();
        ld = $urandom_range(1, 3);
        wr(32'h404, 32'(ld));
        wr(32'h408, 32'h13);
        for (int k = 1; k <= 4 * ld; k++) begin
            @(posedge clk); #1;
            n = k / 4;
            rd("ar_count", 32'h40C, 32'(ld - (n % ld)));
            chk("ar_done", {31'b0, timer_irq}, {31'b0, k >= 4 * ld});
        end
        wr(32'h408, 32'h17);
        rd("ar_w1c", 32'h408, 32'h13);
        rd("ar_w1c_count", 32'h40C, 32'(ld));
        repeat (4 * ld - 2) @(posedge clk);
        wr(32'h408, 32'h17);
        rd("ar_w1c_collide", 32'h408, 32'h17);
        rd("ar_reload", 32'h40C, 32'(ld));
        chk("ar_irq_pre_rst", {31'b0, timer_irq}, 32'h1);
        reset = 1'b1; #1;
        chk("midrun_irq", {31'b0, timer_irq}, 32'h0);
        rd("midrun_count", 32'h40C, 32'h0);
        rd("midrun_ctrl", 32'h408, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // stopping holds COUNT; restart reloads and restarts the prescaler
        ld = $urandom_range(6, 9);
        wr(32'h404, 32'(ld));
        wr(32'h408, 32'h01);
        repeat (4 * (ld - 5) + 1) @(posedge clk);
        wr(32'h408, 32'h00);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            rd("stop_hold", 32'h40C, 32'h5);
        end
        rd("stop_ctrl", 32'h408, 32'h0);
        wr(32'h408, 32'h01);
        rd("restart", 32'h40C, 32'(ld));
        repeat (3) @(posedge clk);
        #1;
        rd("restart_p3", 32'h40C, 32'(ld));
        @(posedge clk); #1;
        rd("restart_p4", 32'h40C, 32'(ld - 1));

        // ALU activity display
        do_reset();
        wr(32'h400, 32'h3C);
        wr(32'h408, 32'h08);
        chk("alu_init", {24'b0, leds}, 32'h01);
        for (int it = 0; it < 4; it++) begin
            alu = 3'($urandom_range(0, 7));
            @(negedge clk);
            alu_control = alu; reg_write = 1'b1;
            @(posedge clk); #1;
            reg_write = 1'b0;
            e_leds = 8'd1 << alu;
            chk("alu_leds", {24'b0, leds}, {24'b0, e_leds});
            alu_control = ~alu;
            repeat (2) @(posedge clk);
            #1;
            chk("alu_hold", {24'b0, leds}, {24'b0, e_leds});
        end
        rd("alu_led_reg", 32'h400, 32'h3C);

        // switch synchronizer latency
        sw_old = 8'h00;
        for (int it = 0; it < 3; it++) begin
            sw_new = it == 0 ? 8'hC3 : sw_old ^ (8'($urandom) | 8'h01);
            @(posedge clk); #1;
            sw_in = sw_new;
            rd("sw_e0", 32'h410, {24'b0, sw_old});
            @(posedge clk); #1;
            rd("sw_e1", 32'h410, {24'b0, sw_old});
            @(posedge clk); #1;
            rd("sw_e2", 32'h410, {24'b0, sw_new});
            sw_old = sw_new;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
